decoder_operand_stage: RTL and testbench
========================================

// Module: decoder_operand_stage
// PURPOSE
// - Decode stage of the core: classifies a 32-bit instruction into an e_kind,
//   drives register-file read selects and assembles the two ALU operands plus destination.
// - The register-file read is combinational; the stage registers kind/val_a/val_b/rd
//   for the execute stage.
// - Combines the kind decode and the argument decode in one block.
// PARAMETERS
// - XLEN    32  data/instruction width (only 32 supported)
// - REG_W   5   register index width
// PORTS
// - clk          in   1      rising-edge clock; only clock of the block
// - rst_n        in   1      asynchronous, active-low reset
// - in_valid     in   1      instruction is valid this cycle
// - instruction  in   32     instruction word
// - rs_sel       out  5      reg-file read port A select (combinational)
// - rs_in        in   32     reg-file data for rs_sel, same cycle
// - rq_sel       out  5      reg-file read port B select (combinational)
// - rq_in        in   32     reg-file data for rq_sel, same cycle
// - out_valid    out  1      registered outputs valid
// - kind         out  e_kind instruction class (registered)
// - val_a        out  32     operand A (registered)
// - val_b        out  32     operand B (registered)
// - rd           out  5      destination register index (registered)
// BEHAVIOUR
// - Encoding: e_kind is 3 bits: INVALID=0, RRR=1, RRI=2, RI=3, J=4.
// - Class field is instr[31:29]: 000=RRR, 001=RRI, 010=RI, 011=J, 1xx=INVALID.
// - Fields: rd=instr[4:0], rs=instr[9:5], rq=instr[14:10].
//   - imm16=instr[25:10], imm21=instr[25:5], imm26=instr[25:0].
//   - All immediates are sign-extended to 32 bits.
// - Combinational selects, derived from the current instruction regardless of in_valid:
//   - RRR: rs_sel=rs, rq_sel=rq.
//   - RRI: rs_sel=rs, rq_sel=0.
//   - RI, J, INVALID: rs_sel=0, rq_sel=0.
// - Next-state operands by kind:
//   - RRR: val_a=rs_in, val_b=rq_in, rd=rd.
//   - RRI: val_a=rs_in, val_b=sext(imm16), rd=rd.
//   - RI: val_a=0, val_b=sext(imm21), rd=rd.
//   - J: val_a=0, val_b=sext(imm26), rd=0.
//   - INVALID: val_a=0, val_b=0, rd=0.
// - Latency: 1 cycle.
//   - On a clk edge with in_valid=1, kind/val_a/val_b/rd load their next-state values
//     and out_valid<=1.
//   - On a clk edge with in_valid=0, out_valid<=0 and the payload holds its last value.
// - Reset: rst_n low forces, immediately and asynchronously:
//   - out_valid=0, kind=INVALID, val_a=0, val_b=0, rd=0.
// - Reset mid-operation: an instruction presented during reset is dropped. The first
//   capture happens on the first clk edge after rst_n deasserts.
// - No back-pressure: the stage accepts one instruction per cycle; back-to-back valids
//   each produce an output one cycle later.
// - Register index 0 is a legal select; the stage gives it no special treatment.
// - No X propagation: every class, including INVALID, drives all outputs to defined values.
// TESTING
// - Reset: rst_n=0 with in_valid=1, instr=0x00000C41
//   -> out_valid=0, kind=INVALID, val_a/val_b/rd=0 without a clk edge.
// - RRR: instr=0x00000C41, rs_in=0x11, rq_in=0x22
//   -> rs_sel=2, rq_sel=3 same cycle.
//   -> next edge: kind=RRR, val_a=0x11, val_b=0x22, rd=1, out_valid=1.
// - RRI sign-extend: instr=0x23FFFC45, rs_in=0xABCD
//   -> rs_sel=2, rq_sel=0.
//   -> next edge: kind=RRI, val_a=0xABCD, val_b=0xFFFFFFFF, rd=5.
// - RI: instr=0x40002007 -> kind=RI, val_a=0, val_b=0x00000100, rd=7, rs_sel=0.
// - J and INVALID:
//   - instr=0x63FFFFFF -> kind=J, val_b=0xFFFFFFFF, rd=0.
//   - instr=0xE0000000 -> kind=INVALID, val_a=val_b=0, rd=0.
// - Valid gating: RRR then in_valid=0 with instr changed to 0x40002007
//   -> out_valid=0, payload still holds the RRR values.

Source files
------------

// File: rtl/decoder_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : decoder_operand_stage
// Description : Decode stage: classifies an instruction, drives reg-file read
//               selects and registers kind / operands / destination.
// Revision    : 1.0 - initial release
// ============================================================================

package decoder_operand_stage_pkg;
    typedef enum logic [2:0] {
        KIND_INVALID = 3'd0,
        KIND_RRR     = 3'd1,
        KIND_RRI     = 3'd2,
        KIND_RI      = 3'd3,
        KIND_J       = 3'd4
    } e_kind;
endpackage

module decoder_operand_stage
    import decoder_operand_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  instruction,
    output logic [REG_W-1:0] rs_sel,
    input  logic [XLEN-1:0]  rs_in,
    output logic [REG_W-1:0] rq_sel,
    input  logic [XLEN-1:0]  rq_in,
    output logic             out_valid,
    output e_kind            kind,
    output logic [XLEN-1:0]  val_a,
    output logic [XLEN-1:0]  val_b,
    output logic [REG_W-1:0] rd
);

    e_kind            w_kind;
    logic [REG_W-1:0] w_rs_sel;
    logic [REG_W-1:0] w_rq_sel;
    logic [XLEN-1:0]  w_val_a;
    logic [XLEN-1:0]  w_val_b;
    logic [REG_W-1:0] w_rd;
    logic [XLEN-1:0]  w_imm16;
    logic [XLEN-1:0]  w_imm21;
    logic [XLEN-1:0]  w_imm26;
    logic             w_unused;

    logic             r_valid;
    e_kind            r_kind;
    logic [XLEN-1:0]  r_val_a;
    logic [XLEN-1:0]  r_val_b;
    logic [REG_W-1:0] r_rd;

    // Class field only uses three bits; the gap between class and immediates is spare.
    assign w_unused = ^instruction[28:26];

    assign w_imm16 = {{16{instruction[25]}}, instruction[25:10]};
    assign w_imm21 = {{11{instruction[25]}}, instruction[25:5]};
    assign w_imm26 = {{6{instruction[25]}},  instruction[25:0]};

    always_comb begin
        w_kind = KIND_INVALID;
        case (instruction[31:29])
            3'b000:  w_kind = KIND_RRR;
            3'b001:  w_kind = KIND_RRI;
            3'b010:  w_kind = KIND_RI;
            3'b011:  w_kind = KIND_J;
            default: w_kind = KIND_INVALID;
        endcase
    end

    // Selects follow the instruction word even when in_valid is low.
    always_comb begin
        w_rs_sel = '0;
        w_rq_sel = '0;
        w_val_a  = '0;
        w_val_b  = '0;
        w_rd     = '0;
        case (w_kind)
            KIND_RRR: begin
                w_rs_sel = instruction[9:5];
                w_rq_sel = instruction[14:10];
                w_val_a  = rs_in;
                w_val_b  = rq_in;
                w_rd     = instruction[4:0];
            end
            KIND_RRI: begin
                w_rs_sel = instruction[9:5];
                w_val_a  = rs_in;
                w_val_b  = w_imm16;
                w_rd     = instruction[4:0];
            end
            KIND_RI: begin
                w_val_b  = w_imm21;
                w_rd     = instruction[4:0];
            end
            KIND_J: begin
                w_val_b  = w_imm26;
            end
            default: begin
                w_val_b  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_kind  <= KIND_INVALID;
            r_val_a <= '0;
            r_val_b <= '0;
            r_rd    <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_kind  <= w_kind;
                r_val_a <= w_val_a;
                r_val_b <= w_val_b;
                r_rd    <= w_rd;
            end
        end
    end

    assign rs_sel    = w_rs_sel;
    assign rq_sel    = w_rq_sel;
    assign out_valid = r_valid;
    assign kind      = r_kind;
    assign val_a     = r_val_a;
    assign val_b     = r_val_b;
    assign rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_decoder_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_operand_stage
// Description : Directed self-checking bench for decoder_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_operand_stage;
    import decoder_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic [4:0]  rs_sel;
    logic [31:0] rs_in;
    logic [4:0]  rq_sel;
    logic [31:0] rq_in;
    logic        out_valid;
    e_kind       kind;
    logic [31:0] val_a;
    logic [31:0] val_b;
    logic [4:0]  rd;

    int errors = 0;
    int checks = 0;

    decoder_operand_stage #(.XLEN(32), .REG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .rs_sel      (rs_sel),
        .rs_in       (rs_in),
        .rq_sel      (rq_sel),
        .rq_in       (rq_in),
        .out_valid   (out_valid),
        .kind        (kind),
        .val_a       (val_a),
        .val_b       (val_b),
        .rd          (rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle and check the combinational selects.
    task automatic apply(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] exp_rs, input logic [4:0] exp_rq,
                         input string tag);
        @(negedge clk);
        in_valid    = v;
        instruction = ins;
        rs_in       = a;
        rq_in       = b;
        #1;
        check({tag, ".rs_sel"}, 32'(rs_sel), 32'(exp_rs));
        check({tag, ".rq_sel"}, 32'(rq_sel), 32'(exp_rq));
    endtask

    task automatic expect_out(input logic v, input logic [2:0] k, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] r, input string tag);
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".kind"},      32'(kind),      32'(k));
        check({tag, ".val_a"},     val_a,          a);
        check({tag, ".val_b"},     val_b,          b);
        check({tag, ".rd"},        32'(rd),        32'(r));
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h0000_0C41;
        rs_in       = 32'h11;
        rq_in       = 32'h22;

        // Asynchronous reset, no clock edge yet
        #1 rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.kind",      32'(kind),      32'd0);
        check("rst.val_a",     val_a,          32'd0);
        check("rst.val_b",     val_b,          32'd0);
        check("rst.rd",        32'(rd),        32'd0);

        // Instruction presented while in reset is dropped
        @(posedge clk); #1;
        check("rst_hold.out_valid", 32'(out_valid), 32'd0);
        check("rst_hold.kind",      32'(kind),      32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        apply(1'b1, 32'h0000_0C41, 32'h11, 32'h22, 5'd2, 5'd3, "rrr");
        expect_out(1'b1, 3'd1, 32'h11, 32'h22, 5'd1, "rrr");

        // Back-to-back valids through every class
        apply(1'b1, 32'h23FF_FC45, 32'hABCD, 32'h5555, 5'd2, 5'd0, "rri_neg");
        expect_out(1'b1, 3'd2, 32'hABCD, 32'hFFFF_FFFF, 5'd5, "rri_neg");

        apply(1'b1, 32'h2004_0422, 32'h5, 32'h77, 5'd1, 5'd0, "rri_pos");
        expect_out(1'b1, 3'd2, 32'h5, 32'h0000_0101, 5'd2, "rri_pos");

        apply(1'b1, 32'h4000_2007, 32'h99, 32'h88, 5'd0, 5'd0, "ri_pos");
        expect_out(1'b1, 3'd3, 32'h0, 32'h0000_0100, 5'd7, "ri_pos");

        apply(1'b1, 32'h43FF_FFE3, 32'h99, 32'h88, 5'd0, 5'd0, "ri_neg");
        expect_out(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, 5'd3, "ri_neg");

        apply(1'b1, 32'h63FF_FFFF, 32'h99, 32'h88, 5'd0, 5'd0, "j_neg");
        expect_out(1'b1, 3'd4, 32'h0, 32'hFFFF_FFFF, 5'd0, "j_neg");

        apply(1'b1, 32'h6000_1234, 32'h99, 32'h88, 5'd0, 5'd0, "j_pos");
        expect_out(1'b1, 3'd4, 32'h0, 32'h0000_1234, 5'd0, "j_pos");

        apply(1'b1, 32'hE000_0000, 32'h99, 32'h88, 5'd0, 5'd0, "inv");
        expect_out(1'b1, 3'd0, 32'h0, 32'h0, 5'd0, "inv");

        apply(1'b1, 32'h9FFF_FFFF, 32'h99, 32'h88, 5'd0, 5'd0, "inv_ones");
        expect_out(1'b1, 3'd0, 32'h0, 32'h0, 5'd0, "inv_ones");

        // Valid gating: payload holds after a bubble
        apply(1'b1, 32'h0000_0C41, 32'h11, 32'h22, 5'd2, 5'd3, "gate_rrr");
        expect_out(1'b1, 3'd1, 32'h11, 32'h22, 5'd1, "gate_rrr");
        apply(1'b0, 32'h4000_2007, 32'h33, 32'h44, 5'd0, 5'd0, "gate_idle");
        expect_out(1'b0, 3'd1, 32'h11, 32'h22, 5'd1, "gate_idle");

        // Mid-cycle reset clears immediately
        apply(1'b1, 32'h23FF_FC45, 32'hABCD, 32'h0, 5'd2, 5'd0, "pre_rst");
        expect_out(1'b1, 3'd2, 32'hABCD, 32'hFFFF_FFFF, 5'd5, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.kind",      32'(kind),      32'd0);
        check("midrst.val_a",     val_a,          32'd0);
        check("midrst.val_b",     val_b,          32'd0);
        check("midrst.rd",        32'(rd),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_out(1'b1, 3'd2, 32'hABCD, 32'hFFFF_FFFF, 5'd5, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
